// File: rtl/mouse_packet_decoder.sv
// mouse_packet_decoder
//   Assembles 3-byte PS/2 mouse movement packets (header, X, Y) from the PS/2
//   byte receiver. It registers the motion magnitudes, the direction flags and
//   the left-button state, and pulses mouseReady for one cycle on every
//   completed packet. It resynchronises on header bit3, saturates the
//   magnitudes on the overflow flags, and drops a partial packet when a
//   receiver error occurs or when the gap between bytes is too long.
//
// Ports
//   clk        in   1   system clock
//   rst        in   1   asynchronous active-high reset
//   rxByte     in   8   received byte, valid when rxValid=1
//   rxValid    in   1   byte strobe
//   rxErr      in   1   parity/framing error strobe (wins over rxValid)
//   vx         out  10  |X| of last packet
//   vy         out  9   |Y| of last packet
//   dx         out  1   X sign (1 = leftward)
//   dy         out  1   Y sign (1 = downward)
//   mousepush  out  1   left button of last packet
//   mouseReady out  1   one-cycle strobe: outputs updated
module mouse_packet_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned CLAMP          = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rxByte,
  input  logic       rxValid,
  input  logic       rxErr,
  output logic [9:0] vx,
  output logic [8:0] vy,
  output logic       dx,
  output logic       dy,
  output logic       mousepush,
  output logic       mouseReady
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [9:0] CLAMP_X = 10'(CLAMP);
  localparam logic [8:0] CLAMP_Y = 9'(CLAMP);

  typedef enum logic [1:0] {B0, B1, B2} state_t;

  state_t        state, state_next;
  logic [7:0]    hdr, xbyte;
  logic [CW-1:0] cnt;
  logic          expire, commit, latch_hdr, latch_x;
  logic [8:0]    x9, y9, xmag, ymag;
  logic [9:0]    vx_new;
  logic [8:0]    vy_new;

  // The bound is hit when this cycle would take the counter to TIMEOUT_CYCLES.
  assign expire = (state != B0) && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= B0;
    else     state <= state_next;
  end

  // Priority: rxErr drops everything, then rxValid (wins over an expiring
  // timeout), then the timeout itself.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    latch_hdr  = 1'b0;
    latch_x    = 1'b0;
    if (rxErr) begin
      state_next = B0;
    end else if (rxValid) begin
      unique case (state)
        B0: if (rxByte[3]) begin
              state_next = B1;
              latch_hdr  = 1'b1;
            end
        B1: begin
              state_next = B2;
              latch_x    = 1'b1;
            end
        B2: begin
              state_next = B0;
              commit     = 1'b1;
            end
        default: state_next = B0;
      endcase
    end else if (expire) begin
      state_next = B0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rxValid || rxErr || state_next == B0) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr   <= '0;
      xbyte <= '0;
    end else begin
      if (latch_hdr) hdr   <= rxByte;
      if (latch_x)   xbyte <= rxByte;
    end
  end

  // 9-bit two's complement; negating -256 wraps to 9'h100, which reads as 256.
  always_comb begin
    x9     = {hdr[4], xbyte};
    y9     = {hdr[5], rxByte};
    xmag   = hdr[4] ? (~x9 + 9'd1) : x9;
    ymag   = hdr[5] ? (~y9 + 9'd1) : y9;
    vx_new = hdr[6] ? CLAMP_X : {1'b0, xmag};
    vy_new = hdr[7] ? CLAMP_Y : ymag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vx         <= '0;
      vy         <= '0;
      dx         <= 1'b0;
      dy         <= 1'b0;
      mousepush  <= 1'b0;
      mouseReady <= 1'b0;
    end else begin
      mouseReady <= commit;
      if (commit) begin
        vx        <= vx_new;
        vy        <= vy_new;
        dx        <= hdr[4];
        dy        <= hdr[5];
        mousepush <= hdr[0];
      end
    end
  end

endmodule
